// File: rtl/msi_write_receiver.sv
// AXI4-Lite write-only MSI target: turns seteipnum_le writes into EIIDs
// and streams them to the interrupt-file pending logic through a FIFO.
module msi_write_receiver #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 'h2800_4000,
  parameter int NR_SRC = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          awvalid_i,
  output logic                          awready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr_i,
  input  logic                          wvalid_i,
  output logic                          wready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
  output logic                          bvalid_o,
  input  logic                          bready_i,
  output logic [1:0]                    bresp_o,
  output logic                          eiid_valid_o,
  input  logic                          eiid_ready_i,
  output logic [$clog2(NR_SRC)-1:0]     eiid_o,
  output logic [15:0]                   drop_cnt_o
);

  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int EW = $clog2(NR_SRC);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW = AXI_ADDR_WIDTH;

  logic [AW-3:0]             addr_q, addr_d;
  logic                      aw_full_q, aw_full_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]             wstrb_q, wstrb_d;
  logic                      w_full_q, w_full_d;
  logic                      bvalid_q, bvalid_d;
  logic                      rdy_q, rdy_d;
  logic [15:0]               drop_q, drop_d;
  logic [EW-1:0]             mem_q [FIFO_DEPTH];
  logic [PW-1:0]             rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]               cnt_q, cnt_d;

  logic [31:0] lane_data;
  logic [3:0]  lane_strb;
  logic        hit, accept, fifo_full, commit, push, pop;
  logic        aw_hs, w_hs;
  logic        unused_addr;

  assign unused_addr = ^awaddr_i[1:0];

  // addr_q[0] is byte-address bit 2, selecting the 32-bit lane
  if (AXI_DATA_WIDTH == 64) begin : g_w64
    assign lane_data = addr_q[0] ? wdata_q[63:32] : wdata_q[31:0];
    assign lane_strb = addr_q[0] ? wstrb_q[7:4] : wstrb_q[3:0];
  end else begin : g_w32
    assign lane_data = wdata_q;
    assign lane_strb = wstrb_q;
  end

  assign hit       = addr_q == BASE_ADDR[AW-1:2];
  assign accept    = hit && lane_strb == 4'hF &&
                     lane_data != 32'd0 &&
                     lane_data < 32'(NR_SRC);
  assign fifo_full = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign commit    = aw_full_q && w_full_q && !bvalid_q &&
                     !(accept && fifo_full);
  assign push      = commit && accept;
  assign pop       = eiid_valid_o && eiid_ready_i;

  assign awready_o    = rdy_q && !aw_full_q && !bvalid_q;
  assign wready_o     = rdy_q && !w_full_q && !bvalid_q;
  assign aw_hs        = awvalid_i && awready_o;
  assign w_hs         = wvalid_i && wready_o;
  assign bvalid_o     = bvalid_q;
  assign bresp_o      = 2'b00;
  assign eiid_valid_o = cnt_q != '0;
  assign eiid_o       = mem_q[rd_q];
  assign drop_cnt_o   = drop_q;

  always_comb begin
    addr_d    = addr_q;
    aw_full_d = aw_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    drop_d    = drop_q;
    rdy_d     = 1'b1;
    if (aw_hs) begin
      addr_d    = awaddr_i[AW-1:2];
      aw_full_d = 1'b1;
    end
    if (w_hs) begin
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
      w_full_d = 1'b1;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (!accept && drop_q != 16'hFFFF)
        drop_d = drop_q + 16'd1;
    end
    if (bvalid_q && bready_i)
      bvalid_d = 1'b0;
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      aw_full_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      rdy_q     <= 1'b0;
      drop_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      addr_q    <= addr_d;
      aw_full_q <= aw_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      rdy_q     <= rdy_d;
      drop_q    <= drop_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      if (push)
        mem_q[wr_q] <= lane_data[EW-1:0];
    end
  end

endmodule

// File: tb/tb_msi_write_receiver.sv
// Bench for msi_write_receiver: vector table, corner sequences and
// randomized writes checked against a queue-based transaction model.
module tb_msi_write_receiver;

  localparam logic [63:0] BASE = 64'h2800_4000;
  localparam int NR = 64;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        awvalid_i = 1'b0;
  logic        awready_o;
  logic [63:0] awaddr_i = '0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [63:0] wdata_i = '0;
  logic [7:0]  wstrb_i = '0;
  logic        bvalid_o;
  logic        bready_i = 1'b0;
  logic [1:0]  bresp_o;
  logic        eiid_valid_o;
  logic        eiid_ready_i;
  logic [5:0]  eiid_o;
  logic [15:0] drop_cnt_o;

  msi_write_receiver dut (
    .clk_i(clk), .rst_i(rst_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o),
    .eiid_valid_o(eiid_valid_o), .eiid_ready_i(eiid_ready_i),
    .eiid_o(eiid_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    bit          acc;
  } vec_t;

  vec_t       tbl[11];
  logic [5:0] exp_q[$];
  int         drop_exp = 0;
  int         nvec = 0;
  int         nerr = 0;
  bit         rnd_en = 1'b0;
  bit         ready_force = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference rule: lane picked by address bit 2, full lane strobes,
  // identity in 1..NR-1, address equal to BASE ignoring bits [1:0].
  function automatic bit model_accept(logic [63:0] a, logic [63:0] d,
                                      logic [7:0] s, output logic [5:0] e);
    logic [31:0] lane;
    logic [3:0]  ls;
    lane = a[2] ? d[63:32] : d[31:0];
    ls   = a[2] ? s[7:4] : s[3:0];
    e    = lane[5:0];
    return (a >> 2) == (BASE >> 2) && ls == 4'hF &&
           lane >= 1 && lane < NR;
  endfunction

  task automatic finish_b(input int bstall);
    bit found = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (bvalid_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("b_seen", 64'(found), 64'd1);
    if (found) begin
      chk("bresp", 64'(bresp_o), 64'd0);
      for (int i = 0; i < bstall; i++) begin
        chk("b_stall", 64'({bvalid_o, awready_o, wready_o}), 64'b100);
        @(negedge clk);
      end
      bready_i = 1'b1;
      @(negedge clk);
      bready_i = 1'b0;
      chk("after_b", 64'({bvalid_o, awready_o, wready_o}), 64'b011);
    end
  endtask

  task automatic axi_write(input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s, input int skew,
                           input int bstall);
    bit aw_done = 1'b0, w_done = 1'b0, hs_aw, hs_w;
    int aw_s = skew > 0 ? skew : 0;
    int w_s  = skew < 0 ? -skew : 0;
    awaddr_i = a;
    wdata_i  = d;
    wstrb_i  = s;
    for (int t = 0; t < 100 && !(aw_done && w_done); t++) begin
      awvalid_i = !aw_done && t >= aw_s;
      wvalid_i  = !w_done && t >= w_s;
      hs_aw = awvalid_i && awready_o;
      hs_w  = wvalid_i && wready_o;
      @(negedge clk);
      if (hs_aw) aw_done = 1'b1;
      if (hs_w) w_done = 1'b1;
    end
    awvalid_i = 1'b0;
    wvalid_i  = 1'b0;
    chk("aw_w_handshake", 64'({aw_done, w_done}), 64'b11);
    finish_b(bstall);
  endtask

  task automatic wr_model(input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input int skew,
                          input int bstall);
    logic [5:0] e;
    if (model_accept(a, d, s, e)) exp_q.push_back(e);
    else drop_exp++;
    axi_write(a, d, s, skew, bstall);
  endtask

  task automatic drain();
    bit done = 1'b0;
    ready_force = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (exp_q.size() == 0 && !eiid_valid_o) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain", 64'(done), 64'd1);
  endtask

  initial begin
    eiid_ready_i = 1'b0;
    tbl[0]  = '{BASE,           64'h5,                   8'h0F, 1'b1};
    tbl[1]  = '{BASE,           64'h0,                   8'h0F, 1'b0};
    tbl[2]  = '{BASE,           64'h40,                  8'h0F, 1'b0};
    tbl[3]  = '{BASE + 64'h4,   64'h5,                   8'hFF, 1'b0};
    tbl[4]  = '{BASE,           64'h5,                   8'h07, 1'b0};
    tbl[5]  = '{BASE + 64'h3,   64'h3F,                  8'hFF, 1'b1};
    tbl[6]  = '{BASE,           64'hFFFF_FFFF_0000_0001, 8'h0F, 1'b1};
    tbl[7]  = '{BASE,           64'h0000_0001_0000_0000, 8'hFF, 1'b0};
    tbl[8]  = '{BASE | 64'h1_0000_0000, 64'h5,           8'h0F, 1'b0};
    tbl[9]  = '{BASE,           64'h102,                 8'h0F, 1'b0};
    tbl[10] = '{BASE,           64'h5,                   8'hF0, 1'b0};

    // EIID consumer and pop checker, all from this one procedure
    fork
      forever begin
        @(negedge clk);
        #1;
        eiid_ready_i = rnd_en ? 1'($urandom) : ready_force;
        #1;
        if (!rst_i && eiid_valid_o && eiid_ready_i) begin
          if (exp_q.size() == 0) chk("pop_unexpected", 64'(eiid_o), 64'h3F00);
          else chk("eiid_order", 64'(eiid_o), 64'(exp_q.pop_front()));
        end
      end
    join_none

    // Power-on reset
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_outs", 64'({awready_o, wready_o, bvalid_o, eiid_valid_o}), 64'b0);
    chk("rst_eiid", 64'(eiid_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    @(negedge clk);
    chk("first_ready", 64'({awready_o, wready_o}), 64'b11);

    // Single write latency
    awaddr_i = BASE; wdata_i = 64'h5; wstrb_i = 8'h0F;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    exp_q.push_back(6'd5);
    @(negedge clk);
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    chk("lat_n1", 64'({bvalid_o, eiid_valid_o}), 64'b00);
    @(negedge clk);
    chk("lat_n2", 64'({bvalid_o, eiid_valid_o}), 64'b11);
    chk("lat_eiid", 64'(eiid_o), 64'd5);
    chk("lat_bresp", 64'(bresp_o), 64'd0);
    chk("lat_drop", 64'(drop_cnt_o), 64'd0);
    bready_i = 1'b1;
    @(negedge clk);
    bready_i = 1'b0;
    chk("lat_bdone", 64'(bvalid_o), 64'd0);
    drain();
    ready_force = 1'b0;

    // W ahead of AW
    wdata_i = 64'h7; wstrb_i = 8'h0F; wvalid_i = 1'b1;
    chk("wfirst_c0", 64'(wready_o), 64'd1);
    @(negedge clk);
    wvalid_i = 1'b0;
    chk("wfirst_c1", 64'(wready_o), 64'd0);
    @(negedge clk);
    chk("wfirst_c2", 64'(wready_o), 64'd0);
    @(negedge clk);
    chk("wfirst_c3", 64'(wready_o), 64'd0);
    awaddr_i = BASE; awvalid_i = 1'b1;
    chk("wfirst_aw", 64'(awready_o), 64'd1);
    exp_q.push_back(6'd7);
    @(negedge clk);
    awvalid_i = 1'b0;
    finish_b(0);
    drain();

    // Vector table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].acc) exp_q.push_back(tbl[i].data[5:0]);
      else drop_exp++;
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3 - 1, 0);
      chk($sformatf("tbl%0d_drop", i), 64'(drop_cnt_o), 64'(drop_exp));
    end
    drain();
    chk("tbl_drop_total", 64'(drop_cnt_o), 64'd8);

    // FIFO full backpressure
    ready_force = 1'b0;
    for (int k = 1; k <= 4; k++) wr_model(BASE, 64'(k), 8'h0F, 0, 0);
    awaddr_i = BASE; wdata_i = 64'h5; wstrb_i = 8'h0F;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    exp_q.push_back(6'd5);
    chk("full_hs", 64'({awready_o, wready_o}), 64'b11);
    @(negedge clk);
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("full_stall", 64'({bvalid_o, awready_o, wready_o}), 64'b000);
      @(negedge clk);
    end
    ready_force = 1'b1;
    @(negedge clk);
    ready_force = 1'b0;
    finish_b(0);
    chk("full_count", 64'(exp_q.size()), 64'd4);
    drain();

    // B channel stall
    wr_model(BASE, 64'h9, 8'h0F, 0, 10);
    drain();

    // Randomized traffic
    rnd_en = 1'b1;
    for (int r = 0; r < 120; r++) begin
      logic [63:0] a, d;
      logic [7:0]  s;
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE | 64'($urandom_range(0, 3));
        3:       a = BASE + 64'h4;
        4:       a = BASE + 64'h8;
        default: a = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) != 0) d = {$urandom, 32'($urandom_range(0, 70))};
      else d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       s = 8'hFF;
        1, 2:    s = 8'h0F;
        default: s = 8'($urandom);
      endcase
      wr_model(a, d, s, int'($urandom_range(0, 4)) - 2,
               int'($urandom_range(0, 2)));
    end
    rnd_en = 1'b0;
    drain();
    chk("rand_drop", 64'(drop_cnt_o), 64'(drop_exp));

    // Reset with entries queued and B pending
    ready_force = 1'b0;
    wr_model(BASE, 64'h3, 8'h0F, 0, 0);
    awaddr_i = BASE; wdata_i = 64'h4; wstrb_i = 8'h0F;
    awvalid_i = 1'b1; wvalid_i = 1'b1;
    @(negedge clk);
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_b", 64'({bvalid_o, eiid_valid_o}), 64'b11);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    drop_exp = 0;
    chk("mid_rst_outs", 64'({awready_o, wready_o, bvalid_o, eiid_valid_o}), 64'b0);
    chk("mid_rst_eiid", 64'(eiid_o), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
    @(negedge clk);
    chk("mid_rst_ready", 64'({awready_o, wready_o, bvalid_o}), 64'b110);
    wr_model(BASE, 64'h5, 8'h0F, 0, 0);
    chk("post_rst_eiid", 64'({eiid_valid_o, 1'b0, eiid_o}), 64'h85);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
